// File: rtl/id_exe_reg_pkg.sv
// id_exe_reg_pkg: shared field widths, exe_cmd encodings, field-group structs and bubble constants
package id_exe_reg_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 4;
  localparam int CMD_W = 4;
  localparam int SHOP_W = 12;
  localparam int IMM24_W = 24;
  localparam int STAT_W = 4;
  localparam logic [CMD_W-1:0] EXE_NOP = 4'b0000;
  localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;
  localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
  localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
    logic imm;
    logic is_mem;
    logic [CMD_W-1:0] exe_cmd;
  } ctrl_t;
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [SHOP_W-1:0] shift_operand;
    logic [IMM24_W-1:0] signed_imm_24;
  } data_t;
  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [STAT_W-1:0] status;
  } regs_t;
  localparam ctrl_t CTRL_NOP = '0;
  localparam data_t DATA_NOP = '0;
  localparam regs_t REGS_NOP = '0;
endpackage

// File: rtl/id_exe_reg_pipe_reg.sv
// pipe_reg: clk/rst/clr/en/d -> q register, priority rst > clr > hold (~en) > load, clears to zero
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : en ? d : q;
endmodule

// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EXE pipeline register; rst > flush (bubble) > freeze (hold) > load, all *_in registered to *_out plus is_mem_out/valid_out
module id_exe_reg
  import id_exe_reg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               freeze,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic               b_in,
  input  logic               s_in,
  input  logic               imm_in,
  input  logic [CMD_W-1:0]   exe_cmd_in,
  input  logic [DATA_W-1:0]  val_rn_in,
  input  logic [DATA_W-1:0]  val_rm_in,
  input  logic [SHOP_W-1:0]  shift_operand_in,
  input  logic [IMM24_W-1:0] signed_imm_24_in,
  input  logic [REG_W-1:0]   dest_in,
  input  logic [REG_W-1:0]   src1_in,
  input  logic [REG_W-1:0]   src2_in,
  input  logic [STAT_W-1:0]  status_in,
  output logic [DATA_W-1:0]  pc_out,
  output logic               wb_en_out,
  output logic               mem_r_en_out,
  output logic               mem_w_en_out,
  output logic               b_out,
  output logic               s_out,
  output logic               imm_out,
  output logic [CMD_W-1:0]   exe_cmd_out,
  output logic [DATA_W-1:0]  val_rn_out,
  output logic [DATA_W-1:0]  val_rm_out,
  output logic [SHOP_W-1:0]  shift_operand_out,
  output logic [IMM24_W-1:0] signed_imm_24_out,
  output logic [REG_W-1:0]   dest_out,
  output logic [REG_W-1:0]   src1_out,
  output logic [REG_W-1:0]   src2_out,
  output logic [STAT_W-1:0]  status_out,
  output logic               is_mem_out,
  output logic               valid_out
);
  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;
  regs_t regs_d, regs_q;
  assign ctrl_d = '{valid: 1'b1, wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                    b: b_in, s: s_in, imm: imm_in, is_mem: mem_r_en_in | mem_w_en_in, exe_cmd: exe_cmd_in};
  assign data_d = '{pc: pc_in, val_rn: val_rn_in, val_rm: val_rm_in,
                    shift_operand: shift_operand_in, signed_imm_24: signed_imm_24_in};
  assign regs_d = '{dest: dest_in, src1: src1_in, src2: src2_in, status: status_in};
  pipe_reg #(.WIDTH($bits(ctrl_t))) u_ctrl (.clk(clk), .rst(rst), .clr(flush), .en(!freeze), .d(ctrl_d), .q(ctrl_q));
  pipe_reg #(.WIDTH($bits(data_t))) u_data (.clk(clk), .rst(rst), .clr(flush), .en(!freeze), .d(data_d), .q(data_q));
  pipe_reg #(.WIDTH($bits(regs_t))) u_regs (.clk(clk), .rst(rst), .clr(flush), .en(!freeze), .d(regs_d), .q(regs_q));
  assign valid_out = ctrl_q.valid;
  assign wb_en_out = ctrl_q.wb_en;
  assign mem_r_en_out = ctrl_q.mem_r_en;
  assign mem_w_en_out = ctrl_q.mem_w_en;
  assign b_out = ctrl_q.b;
  assign s_out = ctrl_q.s;
  assign imm_out = ctrl_q.imm;
  assign is_mem_out = ctrl_q.is_mem;
  assign exe_cmd_out = ctrl_q.exe_cmd;
  assign pc_out = data_q.pc;
  assign val_rn_out = data_q.val_rn;
  assign val_rm_out = data_q.val_rm;
  assign shift_operand_out = data_q.shift_operand;
  assign signed_imm_24_out = data_q.signed_imm_24;
  assign dest_out = regs_q.dest;
  assign src1_out = regs_q.src1;
  assign src2_out = regs_q.src2;
  assign status_out = regs_q.status;
endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: directed + random stimulus for id_exe_reg, checked against a per-cycle output model
module tb_id_exe_reg;
  logic clk = 1'b0;
  logic rst, flush, freeze;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0] exe_cmd_in, dest_in, src1_in, src2_in, status_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, is_mem_out, valid_out;
  logic [3:0] exe_cmd_out, dest_out, src1_out, src2_out, status_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;
  logic [159:0] exp_v, out_v, load_v;
  always #5 clk = ~clk;
  id_exe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .status_in(status_in),
    .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .b_out(b_out), .s_out(s_out), .imm_out(imm_out), .exe_cmd_out(exe_cmd_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .shift_operand_out(shift_operand_out),
    .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .status_out(status_out), .is_mem_out(is_mem_out), .valid_out(valid_out)
  );
  assign out_v = {pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, exe_cmd_out,
                  val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out,
                  dest_out, src1_out, src2_out, status_out, is_mem_out, valid_out};
  assign load_v = {pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, exe_cmd_in,
                   val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
                   dest_in, src1_in, src2_in, status_in, mem_r_en_in | mem_w_en_in, 1'b1};
  always @(posedge clk) begin
    if (rst) begin
      exp_v = '0;
      started = 1'b1;
    end else if (flush) exp_v = '0;
    else if (!freeze) exp_v = load_v;
  end
  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (out_v !== exp_v) begin
        miscompares++;
        $display("FAIL model: got %h want %h", out_v, exp_v);
      end
      if (!valid_out && (wb_en_out || mem_r_en_out || mem_w_en_out || b_out || s_out)) begin
        miscompares++;
        $display("FAIL bubble_ctrl: got %b%b%b%b%b want 00000", wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out);
      end
      if (is_mem_out !== (mem_r_en_out | mem_w_en_out)) begin
        miscompares++;
        $display("FAIL is_mem: got %b want %b", is_mem_out, mem_r_en_out | mem_w_en_out);
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask
  task automatic clear_inputs();
    {pc_in, val_rn_in, val_rm_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = '0;
    {exe_cmd_in, dest_in, src1_in, src2_in, status_in, shift_operand_in, signed_imm_24_in} = '0;
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    freeze = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_status", 32'(status_out), 32'd0);
    chk("reset_cmd", 32'(exe_cmd_out), 32'd0);
    rst = 1'b0;
    pc_in = 32'h0000_0010;
    val_rm_in = 32'hF000_000F;
    shift_operand_in = 12'h0E3;
    mem_r_en_in = 1'b1;
    @(negedge clk);
    chk("load_pc", pc_out, 32'h10);
    chk("load_rm", val_rm_out, 32'hF000_000F);
    chk("load_shift", 32'(shift_operand_out), 32'h0E3);
    chk("load_is_mem", 32'(is_mem_out), 32'd1);
    chk("load_valid", 32'(valid_out), 32'd1);
    dest_in = 4'd3;
    @(negedge clk);
    chk("entry_a_dest", 32'(dest_out), 32'd3);
    dest_in = 4'd7;
    pc_in = 32'h0000_0014;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze_dest", 32'(dest_out), 32'd3);
      chk("freeze_pc", pc_out, 32'h10);
    end
    freeze = 1'b0;
    @(negedge clk);
    chk("release_dest", 32'(dest_out), 32'd7);
    chk("release_pc", pc_out, 32'h14);
    wb_en_in = 1'b1;
    exe_cmd_in = 4'b0010;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wb", 32'(wb_en_out), 32'd0);
    chk("flush_cmd", 32'(exe_cmd_out), 32'd0);
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_is_mem", 32'(is_mem_out), 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("reload_valid", 32'(valid_out), 32'd1);
    chk("reload_cmd", 32'(exe_cmd_out), 32'd2);
    flush = 1'b1;
    freeze = 1'b1;
    @(negedge clk);
    chk("flush_freeze_valid", 32'(valid_out), 32'd0);
    chk("flush_freeze_wb", 32'(wb_en_out), 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("held_bubble_valid", 32'(valid_out), 32'd0);
    freeze = 1'b0;
    status_in = 4'b0101;
    repeat (2) @(negedge clk);
    chk("pre_rst_status", 32'(status_out), 32'd5);
    rst = 1'b1;
    freeze = 1'b1;
    @(negedge clk);
    chk("rst_freeze_valid", 32'(valid_out), 32'd0);
    chk("rst_freeze_pc", pc_out, 32'd0);
    chk("rst_freeze_status", 32'(status_out), 32'd0);
    rst = 1'b0;
    freeze = 1'b0;
    status_in = 4'b1010;
    @(negedge clk);
    chk("post_rst_status", 32'(status_out), 32'hA);
    chk("post_rst_valid", 32'(valid_out), 32'd1);
    for (int i = 0; i < 1000; i++) begin
      rst = ($urandom_range(63) == 0);
      flush = ($urandom_range(7) == 0);
      freeze = ($urandom_range(3) == 0);
      pc_in = $urandom;
      val_rn_in = $urandom;
      val_rm_in = $urandom;
      {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = 6'($urandom);
      exe_cmd_in = 4'($urandom);
      shift_operand_in = 12'($urandom);
      signed_imm_24_in = 24'($urandom);
      {dest_in, src1_in, src2_in, status_in} = 16'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    flush = 1'b0;
    freeze = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
